// File: rtl/seg_display_scheduler_pkg.sv
// seg_sched_pkg: FSM states, display register offsets and source count for seg_display_scheduler.
package seg_sched_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_GNT, WR_HI, WR_LO, RELEASE} state_t;
   localparam logic [7:0] HI_OFS = 8'd0;
   localparam logic [7:0] LO_OFS = 8'd1;
   localparam int N_SRC = 2;
endpackage

// File: rtl/seg_display_scheduler_if.sv
// seg_display_scheduler_if: source handshake and bus request/grant signals of the display scheduler.
interface seg_display_scheduler_if;
   import seg_sched_pkg::*;
   logic [N_SRC-1:0] SRC_VALID;
   logic [N_SRC-1:0] SRC_READY;
   logic [15:0]      SRC0_DATA;
   logic [15:0]      SRC1_DATA;
   logic             BUS_REQ;
   logic             BUS_GNT;
   modport master (input SRC_VALID, SRC0_DATA, SRC1_DATA, BUS_GNT, output SRC_READY, BUS_REQ);
   modport slave (output SRC_VALID, SRC0_DATA, SRC1_DATA, BUS_GNT, input SRC_READY, BUS_REQ);
endinterface

// File: rtl/seg_display_scheduler_arb.sv
// rr_arbiter_2: two-request round-robin; the pointer names the favoured source on a tie.
module rr_arbiter_2 (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       served,
   output logic       grant_valid,
   output logic       grant
);
   logic ptr_q, ptr_d;
   // after an update the source just served loses the tie
   always_comb ptr_d = advance ? ~served : ptr_q;
   always_ff @(posedge CLK) ptr_q <= RESET ? 1'b0 : ptr_d;
   assign grant_valid = |req;
   assign grant = (req == 2'b11) ? ptr_q : req[1];
endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: shares the display registers between two sources, writing high then low byte as bus master.
// Optional SEG_SCHED_HOLDOFF_EN enforces HOLD_CYCLES between completed updates.
module seg_display_scheduler
   import seg_sched_pkg::*;
#(
   parameter logic [7:0]  BASE_ADDR   = 8'hD0,
   parameter logic [23:0] HOLD_CYCLES = 24'd1_000_000
) (
   input  logic                    CLK,
   input  logic                    RESET,
   seg_display_scheduler_if.master sif,
   inout  wire  [7:0]              BUS_ADDR,
   inout  wire  [7:0]              BUS_DATA,
   inout  wire                     BUS_WE,
   output logic                    ACTIVE_SRC,
   output logic                    BUSY
);
   state_t           state_q, state_d;
   logic [15:0]      shadow_q, shadow_d;
   logic [N_SRC-1:0] ready_q, ready_d;
   logic             req_q, req_d;
   logic             win_q, win_d;
   logic             act_q, act_d;
   logic             hold_ok, arb_valid, arb_grant, drive;
   rr_arbiter_2 u_arb (
      .CLK         (CLK),
      .RESET       (RESET),
      .req         (sif.SRC_VALID),
      .advance     (state_q == RELEASE),
      .served      (win_q),
      .grant_valid (arb_valid),
      .grant       (arb_grant)
   );
`ifdef SEG_SCHED_HOLDOFF_EN
   logic [23:0] hold_q, hold_d;
   always_comb hold_d = (state_q == RELEASE) ? HOLD_CYCLES : (hold_q != 24'd0) ? hold_q - 24'd1 : hold_q;
   always_ff @(posedge CLK) hold_q <= RESET ? 24'd0 : hold_d;
   assign hold_ok = (hold_q == 24'd0);
`else
   logic unused_hold;
   assign unused_hold = ^HOLD_CYCLES;
   assign hold_ok = 1'b1;
`endif
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      ready_d  = '0;
      req_d    = req_q;
      win_d    = win_q;
      act_d    = act_q;
      case (state_q)
         IDLE: if (arb_valid && hold_ok) begin
            state_d  = WAIT_GNT;
            ready_d  = arb_grant ? 2'b10 : 2'b01;
            win_d    = arb_grant;
            shadow_d = arb_grant ? sif.SRC1_DATA : sif.SRC0_DATA;
            req_d    = 1'b1;
         end
         WAIT_GNT: state_d = sif.BUS_GNT ? WR_HI : WAIT_GNT;
         WR_HI:    state_d = sif.BUS_GNT ? WR_LO : WAIT_GNT;
         // a lost grant keeps the request up and retries from the high byte
         WR_LO: begin
            state_d = sif.BUS_GNT ? RELEASE : WAIT_GNT;
            req_d   = !sif.BUS_GNT;
         end
         RELEASE: begin
            state_d = IDLE;
            act_d   = win_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         ready_q  <= '0;
         req_q    <= 1'b0;
         win_q    <= 1'b0;
         act_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         ready_q  <= ready_d;
         req_q    <= req_d;
         win_q    <= win_d;
         act_q    <= act_d;
      end
   end
   // lines follow the live grant so the processor is never contended
   assign drive = (state_q == WR_HI || state_q == WR_LO) && sif.BUS_GNT;
   assign BUS_ADDR = drive ? BASE_ADDR + ((state_q == WR_LO) ? LO_OFS : HI_OFS) : 8'hzz;
   assign BUS_DATA = drive ? ((state_q == WR_LO) ? shadow_q[7:0] : shadow_q[15:8]) : 8'hzz;
   assign BUS_WE = drive ? 1'b1 : 1'bz;
   assign sif.SRC_READY = ready_q;
   assign sif.BUS_REQ = req_q;
   assign ACTIVE_SRC = act_q;
   assign BUSY = (state_q != IDLE);
endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler: scoreboard bench; a negedge monitor predicts acceptances and checks every completed display update.
module tb_seg_display_scheduler;
   localparam logic [7:0] BASE = 8'hD0;
   localparam logic [7:0] BASE_P1 = BASE + 8'd1;
   localparam int HOLD = 100;
   typedef struct {logic src; logic [15:0] data;} upd_t;
   logic CLK = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;
   seg_display_scheduler_if sif();
   wire [7:0] bus_addr, bus_data;
   wire       bus_we;
   logic      active_src, busy;
   seg_display_scheduler #(.BASE_ADDR(BASE), .HOLD_CYCLES(24'(HOLD))) dut (
      .CLK(CLK), .RESET(RESET), .sif(sif), .BUS_ADDR(bus_addr), .BUS_DATA(bus_data),
      .BUS_WE(bus_we), .ACTIVE_SRC(active_src), .BUSY(busy));
   int n_tests = 0, n_fail = 0;
   upd_t exp_q[$];
   upd_t e;
   logic [15:0] pend_data [2];
   int cyc = 0, free_at = -1, hold_until = 0;
   int last_rdy_cyc = 0, last_hi_cyc = 0, last_lo_cyc = 0, n_done = 0, n_hi = 0;
   logic rst_prev = 1'b1, m_busy = 1'b0, fav = 1'b0, hi_prev = 1'b0, hi_now, w;
   logic act_pending = 1'b0, act_exp = 1'b0, last_done_src = 1'b0;
   logic [1:0] exp_rdy = 2'b00;
   logic [7:0] hi_data = 8'h00;
   logic random_on = 1'b0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // Monitor: acceptance rule = idle, something valid, tie goes to the source not served last.
   always @(negedge CLK) begin
      cyc++;
      hi_now = 1'b0;
      if (rst_prev) begin
         chk("rst_req", sif.BUS_REQ, 0);
         chk("rst_ready", sif.SRC_READY, 0);
         chk("rst_busy", busy, 0);
         chk("rst_we_z", bus_we === 1'b1, 0);
         chk("rst_active", active_src, 0);
         exp_q.delete();
         m_busy = 1'b0; free_at = -1; fav = 1'b0; act_pending = 1'b0; hold_until = 0;
      end else begin
         chk("src_ready", sif.SRC_READY, exp_rdy);
         if (exp_rdy != 2'b00) begin
            exp_q.push_back('{src: exp_rdy[1], data: pend_data[exp_rdy[1]]});
            m_busy = 1'b1;
            last_rdy_cyc = cyc;
         end
         if (cyc == free_at) m_busy = 1'b0;
         chk("busy", busy, m_busy);
         if (act_pending && cyc == free_at) begin
            chk("active_src", active_src, act_exp);
            act_pending = 1'b0;
         end
         if (bus_we === 1'b1) begin
            chk("no_contention", sif.BUS_GNT, 1);
            if (bus_addr == BASE) begin
               hi_now = 1'b1; hi_data = bus_data; last_hi_cyc = cyc; n_hi++;
            end else begin
               chk("lo_addr", bus_addr, BASE_P1);
               chk("lo_after_hi", hi_prev, 1);
               if (exp_q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL update: write with no accepted request (cycle %0d)", cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("upd_hi_byte", hi_data, e.data[15:8]);
                  chk("upd_lo_byte", bus_data, e.data[7:0]);
                  fav = ~e.src; act_exp = e.src; act_pending = 1'b1;
                  free_at = cyc + 2; last_lo_cyc = cyc; last_done_src = e.src; n_done++;
`ifdef SEG_SCHED_HOLDOFF_EN
                  hold_until = cyc + 2 + HOLD;
`endif
               end
            end
         end
      end
      hi_prev = hi_now;
      exp_rdy = 2'b00;
      if (!RESET && !m_busy && cyc >= hold_until && sif.SRC_VALID != 2'b00) begin
         w = (sif.SRC_VALID == 2'b11) ? fav : sif.SRC_VALID[1];
         exp_rdy = w ? 2'b10 : 2'b01;
      end
      rst_prev = RESET;
   end
   // Sources drop valid once accepted and then scramble their data.
   initial forever begin
      @(posedge CLK); #2;
      for (int s = 0; s < 2; s++)
         if (sif.SRC_READY[s]) begin
            sif.SRC_VALID[s] = 1'b0;
            if (s == 1) sif.SRC1_DATA = 16'($urandom); else sif.SRC0_DATA = 16'($urandom);
         end
   end
   task automatic tick(); @(posedge CLK); #1; endtask
   task automatic raise(input int s, input logic [15:0] d);
      pend_data[s] = d;
      if (s == 1) sif.SRC1_DATA = d; else sif.SRC0_DATA = d;
      sif.SRC_VALID[s] = 1'b1;
   endtask
   task automatic do_reset();
      RESET = 1'b1; sif.SRC_VALID = 2'b00;
      repeat (3) tick();
      RESET = 1'b0;
   endtask
   task automatic wait_done(input int target, input string name);
      int i = 0;
      while (n_done < target && i < 600) begin tick(); i++; end
      chk(name, n_done >= target, 1);
   endtask
   task automatic wait_hi(input string name);
      int i = 0;
      while (!(bus_we === 1'b1 && bus_addr == BASE) && i < 600) begin tick(); i++; end
      chk(name, bus_we === 1'b1 && bus_addr == BASE, 1);
   endtask
   initial begin
      int base, gnt_cyc, hi0, lo1, i;
      sif.SRC_VALID = 2'b00; sif.SRC0_DATA = '0; sif.SRC1_DATA = '0; sif.BUS_GNT = 1'b0;
      pend_data[0] = '0; pend_data[1] = '0;
      do_reset();
      // single source, grant tied high
      sif.BUS_GNT = 1'b1;
      base = n_done;
      raise(0, 16'h1234);
      wait_done(base + 1, "t1_done");
      chk("t1_lat_hi", last_hi_cyc - last_rdy_cyc, 1);
      chk("t1_lat_lo", last_lo_cyc - last_rdy_cyc, 2);
      chk("t1_src", last_done_src, 0);
      repeat (3) tick();
      // both sources at once, twice
      do_reset();
      sif.BUS_GNT = 1'b1;
      for (int r = 0; r < 2; r++) begin
         base = n_done;
         raise(0, 16'hAAAA); raise(1, 16'h5555);
         wait_done(base + 1, "t2_first");
         chk("t2_first_src", last_done_src, 0);
         lo1 = last_lo_cyc;
         wait_done(base + 2, "t2_second");
         chk("t2_second_src", last_done_src, 1);
`ifdef SEG_SCHED_HOLDOFF_EN
         chk("t2_holdoff_gap", (last_rdy_cyc - lo1) > HOLD, 1);
`else
         chk("t2_back_to_back", last_rdy_cyc - lo1, 3);
`endif
      end
      // grant withheld for 20 cycles
      do_reset();
      sif.BUS_GNT = 1'b0;
      base = n_done;
      raise(0, 16'hBEEF);
      repeat (20) begin
         tick();
         chk("t3_req_high", sif.BUS_REQ, 1);
         chk("t3_we_z", bus_we === 1'b1, 0);
      end
      sif.BUS_GNT = 1'b1;
      gnt_cyc = cyc + 1;
      wait_done(base + 1, "t3_done");
      chk("t3_lat_after_gnt", last_hi_cyc - gnt_cyc, 1);
      // grant lost in the low-byte cycle
      base = n_done;
      hi0 = n_hi;
      raise(1, 16'hC3A5);
      wait_hi("t4_hi_seen");
      tick();
      sif.BUS_GNT = 1'b0;
      repeat (3) begin
         tick();
         chk("t4_req_held", sif.BUS_REQ, 1);
      end
      sif.BUS_GNT = 1'b1;
      wait_done(base + 1, "t4_done");
      chk("t4_hi_twice", n_hi - hi0, 2);
      // reset in the high-byte cycle
      base = n_done;
      raise(0, 16'h0F0F);
      wait_hi("t5_hi_seen");
      RESET = 1'b1;
      tick();
      chk("t5_we_z", bus_we === 1'b1, 0);
      chk("t5_req", sif.BUS_REQ, 0);
      chk("t5_busy", busy, 0);
      RESET = 1'b0; sif.SRC_VALID = 2'b00;
      repeat (3) tick();
      chk("t5_no_update", n_done, base);
      // random traffic with a flaky grant
      for (int c = 0; c < 800; c++) begin
         tick();
         sif.BUS_GNT = ($urandom_range(0, 4) != 0);
         for (int s = 0; s < 2; s++)
            if (!sif.SRC_VALID[s] && !sif.SRC_READY[s] && $urandom_range(0, 3) == 0)
               raise(s, 16'($urandom));
      end
      sif.BUS_GNT = 1'b1;
      i = 0;
      while ((sif.SRC_VALID != 2'b00 || exp_q.size() != 0 || busy) && i < 2000) begin tick(); i++; end
      chk("drain", sif.SRC_VALID != 2'b00 || exp_q.size() != 0 || busy, 0);
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
